elevator_car: RTL

Single elevator car controller: the responder to the two-car dispatch comparator. It accepts a one-hot floor request when the dispatcher raises its enable. It then moves one floor at a time toward the target, opens the door for a fixed time, and returns to idle. Its one-hot floor output feeds back into the comparator's per-car state inputs, so one instance exists per car, each driven by its own enable.

---
 rtl/elevator_car.sv | 122 ++++++++++++
 1 files changed

// File: rtl/elevator_car.sv
// Single elevator car: accepts a one-hot floor request in IDLE, steps one floor
// every FLOOR_TICKS cycles toward it, then holds the door open for DOOR_TICKS cycles.
module elevator_car #(
    parameter int FLOOR_TICKS = 4,
    parameter int DOOR_TICKS  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] targetFloor,
    output logic [3:0] stateElev,
    output logic       busy,
    output logic       dirUp,
    output logic       dirDown,
    output logic       doorOpen,
    output logic       arrived
);

    localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] FLOOR_LAST = CNT_W'(FLOOR_TICKS - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST  = CNT_W'(DOOR_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t           state, state_next;
    logic [3:0]       target, target_next;
    logic [3:0]       floor_next, stepped;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             busy_next, up_next, down_next, door_next, arrived_next;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            stateElev <= 4'b0001;
            target    <= 4'b0001;
            cnt       <= '0;
            busy      <= 1'b0;
            dirUp     <= 1'b0;
            dirDown   <= 1'b0;
            doorOpen  <= 1'b0;
            arrived   <= 1'b0;
        end else begin
            state     <= state_next;
            stateElev <= floor_next;
            target    <= target_next;
            cnt       <= cnt_next;
            busy      <= busy_next;
            dirUp     <= up_next;
            dirDown   <= down_next;
            doorOpen  <= door_next;
            arrived   <= arrived_next;
        end
    end

    always_comb begin
        state_next   = state;
        floor_next   = stateElev;
        target_next  = target;
        cnt_next     = cnt;
        busy_next    = busy;
        up_next      = dirUp;
        down_next    = dirDown;
        door_next    = doorOpen;
        arrived_next = 1'b0;
        // One-hot compare as unsigned integers: a higher bit is a higher floor.
        stepped      = dirUp ? {stateElev[2:0], 1'b0} : {1'b0, stateElev[3:1]};

        unique case (state)
            IDLE: begin
                if (enable && is_onehot(targetFloor)) begin
                    target_next = targetFloor;
                    cnt_next    = '0;
                    busy_next   = 1'b1;
                    if (targetFloor == stateElev) begin
                        state_next   = DOOR;
                        door_next    = 1'b1;
                        arrived_next = 1'b1;
                    end else begin
                        state_next = MOVE;
                        up_next    = (targetFloor > stateElev);
                        down_next  = (targetFloor < stateElev);
                    end
                end
            end
            MOVE: begin
                if (cnt == FLOOR_LAST) begin
                    floor_next = stepped;
                    cnt_next   = '0;
                    if (stepped == target) begin
                        state_next   = DOOR;
                        up_next      = 1'b0;
                        down_next    = 1'b0;
                        door_next    = 1'b1;
                        arrived_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            DOOR: begin
                if (cnt == DOOR_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    door_next  = 1'b0;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
